// File: rtl/sprite_pkg.sv
// Shared constants for the sprite motion engine: keycodes, motion states and
// wall_hit bit positions.
package sprite_pkg;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCEL = 2'd1,
    COAST = 2'd2
  } state_e;

  localparam int WH_LEFT   = 0;
  localparam int WH_RIGHT  = 1;
  localparam int WH_BOTTOM = 2;
  localparam int WH_TOP    = 3;

  // Opposing keys on one axis cancel to 0.
  function automatic logic signed [1:0] axis_dir(input logic neg, input logic pos);
    logic signed [1:0] d;
    d = 2'sb00;
    if (pos && !neg) d = 2'sb01;
    else if (neg && !pos) d = 2'sb11;
    return d;
  endfunction

endpackage

// File: rtl/sprite_axis.sv
// One axis of sprite motion: velocity ramp/coast/saturate, position update and
// edge clamp or bounce, with a registered one-frame hit pulse per side.
module sprite_axis #(
  parameter int WIDTH     = 10,
  parameter int VW        = 5,
  parameter int MIN       = 0,
  parameter int MAX       = 639,
  parameter int CENTER    = 320,
  parameter int SIZE      = 4,
  parameter int MAX_SPEED = 4,
  parameter int ACCEL     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic signed [1:0]    dir_i,
  input  logic                 inertia_en_i,
  input  logic                 bounce_en_i,
  input  logic                 recenter_i,
  output logic [WIDTH-1:0]     pos_o,
  output logic signed [VW-1:0] vel_o,
  output logic signed [VW-1:0] vel_nxt_o,
  output logic                 hit_lo_o,
  output logic                 hit_hi_o
);

  typedef logic signed [VW+1:0]    vext_t;
  typedef logic signed [WIDTH+1:0] pext_t;

  localparam vext_t VMAX  = vext_t'(MAX_SPEED);
  localparam vext_t VSTEP = vext_t'(ACCEL);
  localparam pext_t P_LO  = pext_t'(MIN + SIZE);
  localparam pext_t P_HI  = pext_t'(MAX - SIZE);
  localparam logic [WIDTH-1:0] POS_LO  = WIDTH'(MIN + SIZE);
  localparam logic [WIDTH-1:0] POS_HI  = WIDTH'(MAX - SIZE);
  localparam logic [WIDTH-1:0] POS_CTR = WIDTH'(CENTER);

  logic [WIDTH-1:0]     pos_q, pos_d;
  logic signed [VW-1:0] vel_q, vel_d;
  logic                 hit_lo_q, hit_lo_d;
  logic                 hit_hi_q, hit_hi_d;

  vext_t       v_cur;
  vext_t       v_new;
  logic [VW-1:0] v_mag;
  pext_t       p_new;

  always_comb begin
    v_cur = vext_t'(vel_q);
    v_new = '0;
    if (dir_i == 2'sb01) begin
      v_new = v_cur + VSTEP;
      if (v_new > VMAX) v_new = VMAX;
    end else if (dir_i == 2'sb11) begin
      v_new = v_cur - VSTEP;
      if (v_new < -VMAX) v_new = -VMAX;
    end else if (inertia_en_i) begin
      // Coast toward rest without overshooting zero.
      if (v_cur > VSTEP) v_new = v_cur - VSTEP;
      else if (v_cur < -VSTEP) v_new = v_cur + VSTEP;
      else v_new = '0;
    end

    v_mag = v_new[VW+1] ? -v_new[VW-1:0] : v_new[VW-1:0];
    p_new = $signed({2'b00, pos_q}) + pext_t'(v_new);

    pos_d    = p_new[WIDTH-1:0];
    vel_d    = v_new[VW-1:0];
    hit_lo_d = 1'b0;
    hit_hi_d = 1'b0;

    if (recenter_i) begin
      pos_d = POS_CTR;
      vel_d = '0;
    end else if (p_new < P_LO) begin
      pos_d    = POS_LO;
      hit_lo_d = 1'b1;
      vel_d    = bounce_en_i ? v_mag : '0;
    end else if (p_new > P_HI) begin
      pos_d    = POS_HI;
      hit_hi_d = 1'b1;
      vel_d    = bounce_en_i ? -v_mag : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pos_q    <= POS_CTR;
      vel_q    <= '0;
      hit_lo_q <= 1'b0;
      hit_hi_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      vel_q    <= vel_d;
      hit_lo_q <= hit_lo_d;
      hit_hi_q <= hit_hi_d;
    end
  end

  assign pos_o     = pos_q;
  assign vel_o     = vel_q;
  assign vel_nxt_o = vel_d;
  assign hit_lo_o  = hit_lo_q;
  assign hit_hi_o  = hit_hi_q;

endmodule

// File: rtl/sprite_motion.sv
// Keyboard-driven sprite motion engine: key decode, motion FSM and output
// assembly around two sprite_axis instances, one update per frame.
//   state | meaning
//   IDLE  | at rest, no direction held
//   ACCEL | at least one direction held
//   COAST | no direction held, still moving under inertia or bounce
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int VW        = 5,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int SIZE      = 4,
  parameter int MAX_SPEED = 4,
  parameter int ACCEL     = 1
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic [7:0]           keycode0,
  input  logic [7:0]           keycode1,
  input  logic                 inertia_en,
  input  logic                 bounce_en,
  input  logic                 recenter,
  output logic [WIDTH-1:0]     SpriteX,
  output logic [WIDTH-1:0]     SpriteY,
  output logic [WIDTH-1:0]     SpriteS,
  output logic signed [VW-1:0] VelX,
  output logic signed [VW-1:0] VelY,
  output logic                 moving,
  output logic [3:0]           wall_hit
);

  logic key_a, key_d, key_s, key_w;
  logic signed [1:0] dir_x, dir_y;

  assign key_a = (keycode0 == KEY_A) || (keycode1 == KEY_A);
  assign key_d = (keycode0 == KEY_D) || (keycode1 == KEY_D);
  assign key_s = (keycode0 == KEY_S) || (keycode1 == KEY_S);
  assign key_w = (keycode0 == KEY_W) || (keycode1 == KEY_W);

  assign dir_x = axis_dir(key_a, key_d);
  assign dir_y = axis_dir(key_w, key_s);

  logic signed [VW-1:0] vel_nxt_x, vel_nxt_y;
  logic x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;

  sprite_axis #(
    .WIDTH(WIDTH), .VW(VW), .MIN(X_MIN), .MAX(X_MAX), .CENTER(X_CENTER),
    .SIZE(SIZE), .MAX_SPEED(MAX_SPEED), .ACCEL(ACCEL)
  ) u_axis_x (
    .clk_i        (frame_clk),
    .rst_n_i      (Reset_n),
    .dir_i        (dir_x),
    .inertia_en_i (inertia_en),
    .bounce_en_i  (bounce_en),
    .recenter_i   (recenter),
    .pos_o        (SpriteX),
    .vel_o        (VelX),
    .vel_nxt_o    (vel_nxt_x),
    .hit_lo_o     (x_hit_lo),
    .hit_hi_o     (x_hit_hi)
  );

  sprite_axis #(
    .WIDTH(WIDTH), .VW(VW), .MIN(Y_MIN), .MAX(Y_MAX), .CENTER(Y_CENTER),
    .SIZE(SIZE), .MAX_SPEED(MAX_SPEED), .ACCEL(ACCEL)
  ) u_axis_y (
    .clk_i        (frame_clk),
    .rst_n_i      (Reset_n),
    .dir_i        (dir_y),
    .inertia_en_i (inertia_en),
    .bounce_en_i  (bounce_en),
    .recenter_i   (recenter),
    .pos_o        (SpriteY),
    .vel_o        (VelY),
    .vel_nxt_o    (vel_nxt_y),
    .hit_lo_o     (y_hit_lo),
    .hit_hi_o     (y_hit_hi)
  );

  state_e state_q, state_d;
  logic   any_dir, any_vel;

  assign any_dir = (dir_x != 2'sb00) || (dir_y != 2'sb00);
  // The FSM looks at the velocities this edge will load, not the current ones.
  assign any_vel = (vel_nxt_x != '0) || (vel_nxt_y != '0);

  always_comb begin
    state_d = state_q;
    if (recenter) begin
      state_d = sprite_pkg::IDLE;
    end else begin
      case (state_q)
        sprite_pkg::IDLE: begin
          if (any_dir) state_d = sprite_pkg::ACCEL;
        end
        sprite_pkg::ACCEL: begin
          if (!any_dir) state_d = any_vel ? sprite_pkg::COAST : sprite_pkg::IDLE;
        end
        sprite_pkg::COAST: begin
          if (any_dir) state_d = sprite_pkg::ACCEL;
          else if (!any_vel) state_d = sprite_pkg::IDLE;
        end
        default: state_d = sprite_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= sprite_pkg::IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    wall_hit            = '0;
    wall_hit[WH_LEFT]   = x_hit_lo;
    wall_hit[WH_RIGHT]  = x_hit_hi;
    wall_hit[WH_BOTTOM] = y_hit_hi;
    wall_hit[WH_TOP]    = y_hit_lo;
  end

  assign moving  = (state_q != sprite_pkg::IDLE);
  assign SpriteS = WIDTH'(SIZE);

endmodule

// File: tb/tb_sprite_motion.sv
// Self-checking bench for sprite_motion: directed vector table, hand-built
// wall/corner/reset sequences and randomized play against a behavioural model.
module tb_sprite_motion;

  localparam int XL = 4, XH = 635, YL = 4, YH = 475;
  localparam int VMAXI = 4, ACC = 1;

  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic [7:0]  keycode0, keycode1;
  logic        inertia_en, bounce_en, recenter;
  logic [9:0]  SpriteX, SpriteY, SpriteS;
  logic signed [4:0] VelX, VelY;
  logic        moving;
  logic [3:0]  wall_hit;

  always #5 frame_clk = ~frame_clk;

  sprite_motion dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .keycode0   (keycode0),
    .keycode1   (keycode1),
    .inertia_en (inertia_en),
    .bounce_en  (bounce_en),
    .recenter   (recenter),
    .SpriteX    (SpriteX),
    .SpriteY    (SpriteY),
    .SpriteS    (SpriteS),
    .VelX       (VelX),
    .VelY       (VelY),
    .moving     (moving),
    .wall_hit   (wall_hit)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int   mx, my, mvx, mvy;
  bit   mmov;
  logic [3:0] mhit;

  typedef struct {
    logic [7:0] k0, k1;
    bit inr, bnc, rc;
    int x, y, vx, vy;
    bit mv;
    logic [3:0] hit;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(logic [7:0] k0, logic [7:0] k1, bit inr, bit bnc, bit rc,
                              int x, int y, int vx, int vy, bit mv, logic [3:0] hit);
    vec_t v;
    v.k0 = k0; v.k1 = k1; v.inr = inr; v.bnc = bnc; v.rc = rc;
    v.x = x; v.y = y; v.vx = vx; v.vy = vy; v.mv = mv; v.hit = hit;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int vel_upd(int v, int d, bit inr);
    int r;
    if (d != 0) begin
      r = v + d * ACC;
      if (r > VMAXI) r = VMAXI;
      if (r < -VMAXI) r = -VMAXI;
    end else if (inr) begin
      if (v > 0) r = (v - ACC > 0) ? v - ACC : 0;
      else if (v < 0) r = (v + ACC < 0) ? v + ACC : 0;
      else r = 0;
    end else begin
      r = 0;
    end
    return r;
  endfunction

  task automatic axis_upd(inout int pos, inout int v, input int d, input bit inr, input bit bnc,
                          input int lo, input int hi, output bit hl, output bit hh);
    int vn, p, mag;
    vn = vel_upd(v, d, inr);
    p = pos + vn;
    mag = (vn < 0) ? -vn : vn;
    hl = 0; hh = 0;
    if (p < lo) begin
      pos = lo; hl = 1; v = bnc ? mag : 0;
    end else if (p > hi) begin
      pos = hi; hh = 1; v = bnc ? -mag : 0;
    end else begin
      pos = p; v = vn;
    end
  endtask

  function automatic bit held(logic [7:0] k0, logic [7:0] k1, logic [7:0] k);
    return (k0 == k) || (k1 == k);
  endfunction

  task automatic model_reset();
    mx = 320; my = 240; mvx = 0; mvy = 0; mmov = 0; mhit = 4'b0000;
  endtask

  task automatic model_step(input logic [7:0] k0, input logic [7:0] k1,
                            input bit inr, input bit bnc, input bit rc);
    int dx, dy;
    bit xl, xh, yl, yh;
    if (rc) begin
      model_reset();
    end else begin
      dx = int'(held(k0, k1, 8'h07)) - int'(held(k0, k1, 8'h04));
      dy = int'(held(k0, k1, 8'h16)) - int'(held(k0, k1, 8'h1A));
      axis_upd(mx, mvx, dx, inr, bnc, XL, XH, xl, xh);
      axis_upd(my, mvy, dy, inr, bnc, YL, YH, yl, yh);
      mhit = {yl, yh, xh, xl};
      mmov = (dx != 0) || (dy != 0) || (mvx != 0) || (mvy != 0);
    end
  endtask

  task automatic tick(input logic [7:0] k0, input logic [7:0] k1,
                      input bit inr, input bit bnc, input bit rc);
    keycode0 = k0; keycode1 = k1; inertia_en = inr; bounce_en = bnc; recenter = rc;
    model_step(k0, k1, inr, bnc, rc);
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".x"}, int'(SpriteX), mx);
    check({tag, ".y"}, int'(SpriteY), my);
    check({tag, ".vx"}, int'(VelX), mvx);
    check({tag, ".vy"}, int'(VelY), mvy);
    check({tag, ".moving"}, int'(moving), int'(mmov));
    check({tag, ".wall_hit"}, int'(wall_hit), int'(mhit));
  endtask

  task automatic hold(input logic [7:0] k0, input logic [7:0] k1, input bit inr,
                      input bit bnc, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(k0, k1, inr, bnc, 1'b0);
      check_model(tag);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".x"}, int'(SpriteX), 320);
    check({tag, ".y"}, int'(SpriteY), 240);
    check({tag, ".s"}, int'(SpriteS), 4);
    check({tag, ".vx"}, int'(VelX), 0);
    check({tag, ".vy"}, int'(VelY), 0);
    check({tag, ".moving"}, int'(moving), 0);
    check({tag, ".wall_hit"}, int'(wall_hit), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keyset [5];
    logic [7:0] rk0, rk1;
    bit rinr, rbnc, rrc;
    int run;

    keyset = '{8'h00, 8'h04, 8'h07, 8'h16, 8'h1A};

    tbl[0]  = mk(8'h07, 8'h00, 0, 0, 0, 321, 240, 1, 0, 1, 4'h0);
    tbl[1]  = mk(8'h07, 8'h00, 0, 0, 0, 323, 240, 2, 0, 1, 4'h0);
    tbl[2]  = mk(8'h07, 8'h00, 0, 0, 0, 326, 240, 3, 0, 1, 4'h0);
    tbl[3]  = mk(8'h07, 8'h00, 0, 0, 0, 330, 240, 4, 0, 1, 4'h0);
    tbl[4]  = mk(8'h07, 8'h00, 0, 0, 0, 334, 240, 4, 0, 1, 4'h0);
    tbl[5]  = mk(8'h07, 8'h00, 0, 0, 0, 338, 240, 4, 0, 1, 4'h0);
    tbl[6]  = mk(8'h00, 8'h00, 1, 0, 0, 341, 240, 3, 0, 1, 4'h0);
    tbl[7]  = mk(8'h00, 8'h00, 1, 0, 0, 343, 240, 2, 0, 1, 4'h0);
    tbl[8]  = mk(8'h00, 8'h00, 1, 0, 0, 344, 240, 1, 0, 1, 4'h0);
    tbl[9]  = mk(8'h00, 8'h00, 1, 0, 0, 344, 240, 0, 0, 0, 4'h0);
    tbl[10] = mk(8'h00, 8'h00, 0, 0, 1, 320, 240, 0, 0, 0, 4'h0);
    tbl[11] = mk(8'h07, 8'h1A, 0, 0, 0, 321, 239, 1, -1, 1, 4'h0);
    tbl[12] = mk(8'h07, 8'h1A, 0, 0, 0, 323, 237, 2, -2, 1, 4'h0);
    tbl[13] = mk(8'h00, 8'h00, 1, 0, 0, 324, 236, 1, -1, 1, 4'h0);
    tbl[14] = mk(8'h00, 8'h00, 1, 0, 1, 320, 240, 0, 0, 0, 4'h0);
    tbl[15] = mk(8'h07, 8'h00, 0, 0, 0, 321, 240, 1, 0, 1, 4'h0);
    tbl[16] = mk(8'h07, 8'h00, 0, 0, 1, 320, 240, 0, 0, 0, 4'h0);
    tbl[17] = mk(8'h07, 8'h00, 0, 0, 0, 321, 240, 1, 0, 1, 4'h0);
    tbl[18] = mk(8'h07, 8'h00, 0, 0, 0, 323, 240, 2, 0, 1, 4'h0);
    tbl[19] = mk(8'h00, 8'h00, 0, 0, 0, 323, 240, 0, 0, 0, 4'h0);
    tbl[20] = mk(8'h04, 8'h07, 0, 0, 0, 323, 240, 0, 0, 0, 4'h0);
    tbl[21] = mk(8'h55, 8'h00, 1, 0, 0, 323, 240, 0, 0, 0, 4'h0);
    tbl[22] = mk(8'h16, 8'h00, 0, 0, 0, 323, 241, 0, 1, 1, 4'h0);
    tbl[23] = mk(8'h00, 8'h1A, 1, 0, 0, 323, 241, 0, 0, 1, 4'h0);
    tbl[24] = mk(8'h00, 8'h00, 1, 0, 0, 323, 241, 0, 0, 0, 4'h0);
    tbl[25] = mk(8'h07, 8'h00, 1, 0, 0, 324, 241, 1, 0, 1, 4'h0);
    tbl[26] = mk(8'h07, 8'h00, 1, 0, 0, 326, 241, 2, 0, 1, 4'h0);
    tbl[27] = mk(8'h00, 8'h00, 1, 0, 0, 327, 241, 1, 0, 1, 4'h0);
    tbl[28] = mk(8'h00, 8'h00, 0, 0, 0, 327, 241, 0, 0, 0, 4'h0);

    Reset_n = 1'b0;
    keycode0 = 8'h00; keycode1 = 8'h00;
    inertia_en = 1'b0; bounce_en = 1'b0; recenter = 1'b0;
    model_reset();
    #12;
    check_reset_vals("reset");
    @(negedge frame_clk);
    Reset_n = 1'b1;
    @(posedge frame_clk);
    #1;

    for (int i = 0; i < 29; i++) begin
      tick(tbl[i].k0, tbl[i].k1, tbl[i].inr, tbl[i].bnc, tbl[i].rc);
      check($sformatf("vec%0d.x", i), int'(SpriteX), tbl[i].x);
      check($sformatf("vec%0d.y", i), int'(SpriteY), tbl[i].y);
      check($sformatf("vec%0d.vx", i), int'(VelX), tbl[i].vx);
      check($sformatf("vec%0d.vy", i), int'(VelY), tbl[i].vy);
      check($sformatf("vec%0d.moving", i), int'(moving), int'(tbl[i].mv));
      check($sformatf("vec%0d.wall_hit", i), int'(wall_hit), int'(tbl[i].hit));
    end

    // Left wall, clamp mode
    tick(8'h00, 8'h00, 0, 0, 1);
    check_model("rc1");
    hold(8'h04, 8'h00, 0, 0, 80, "runleft");
    check("left.pre_x", int'(SpriteX), 6);
    check("left.pre_vx", int'(VelX), -4);
    tick(8'h04, 8'h00, 0, 0, 0);
    check("left.x", int'(SpriteX), 4);
    check("left.vx", int'(VelX), 0);
    check("left.wall_hit", int'(wall_hit), 1);
    tick(8'h00, 8'h00, 0, 0, 0);
    check("left.after_x", int'(SpriteX), 4);
    check("left.after_hit", int'(wall_hit), 0);
    check("left.after_moving", int'(moving), 0);

    // Bottom-right corner, bounce mode
    tick(8'h00, 8'h00, 1, 1, 1);
    check_model("rc2");
    hold(8'h07, 8'h00, 1, 1, 20, "trip");
    hold(8'h00, 8'h00, 1, 1, 4, "tripcoast");
    check("trip.x", int'(SpriteX), 400);
    check("trip.moving", int'(moving), 0);
    for (int i = 0; i < 3; i++) begin
      hold(8'h07, 8'h16, 1, 1, 1, "tap");
      hold(8'h00, 8'h00, 1, 1, 1, "taprel");
    end
    check("tap.x", int'(SpriteX), 403);
    check("tap.y", int'(SpriteY), 243);
    hold(8'h07, 8'h16, 1, 1, 59, "diag");
    check("corner.pre_x", int'(SpriteX), 633);
    check("corner.pre_y", int'(SpriteY), 473);
    tick(8'h07, 8'h16, 1, 1, 0);
    check("corner.x", int'(SpriteX), 635);
    check("corner.y", int'(SpriteY), 475);
    check("corner.vx", int'(VelX), -4);
    check("corner.vy", int'(VelY), -4);
    check("corner.wall_hit", int'(wall_hit), 6);
    tick(8'h00, 8'h00, 1, 1, 0);
    check_model("corner.next");
    check("corner.next_hit", int'(wall_hit), 0);

    // Randomized play against the model
    tick(8'h00, 8'h00, 0, 0, 1);
    check_model("rc3");
    run = 0;
    rk0 = 8'h00; rk1 = 8'h00; rinr = 0; rbnc = 0;
    for (int f = 0; f < 3000; f++) begin
      if (run == 0) begin
        run = $urandom_range(1, 40);
        rk0 = ($urandom_range(0, 9) == 0) ? 8'($urandom) : keyset[$urandom_range(0, 4)];
        rk1 = keyset[$urandom_range(0, 4)];
        rinr = 1'($urandom_range(0, 1));
        rbnc = 1'($urandom_range(0, 1));
      end
      run--;
      rrc = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) rinr = ~rinr;
      tick(rk0, rk1, rinr, rbnc, rrc);
      check_model("rand");
    end

    // Asynchronous reset mid-motion
    hold(8'h07, 8'h16, 0, 0, 3, "premid");
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("midreset");
    @(posedge frame_clk);
    #1;
    check_reset_vals("midreset.held");
    @(negedge frame_clk);
    Reset_n = 1'b1;
    hold(8'h07, 8'h00, 0, 0, 2, "postreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
